// File: rtl/bit_stream_encoder.sv
// Serialises SYNC/PID/token/data/handshake packets into a pre-stuffing
// NRZ bit stream, marking the first and final bit of each packet.
module bit_stream_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        pkt_avail,
    input  logic [7:0]  pid_in,
    input  logic [6:0]  addr_in,
    input  logic [3:0]  endp_in,
    input  logic [63:0] data_in,
    input  logic        stall,
    output logic        bit_out,
    output logic        start,
    output logic        last
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SYNC  = 3'd1;
    localparam logic [2:0] PID   = 3'd2;
    localparam logic [2:0] ADDR  = 3'd3;
    localparam logic [2:0] ENDP  = 3'd4;
    localparam logic [2:0] CRC5  = 3'd5;
    localparam logic [2:0] DATA  = 3'd6;
    localparam logic [2:0] CRC16 = 3'd7;

    logic [2:0]  r_state;
    logic [5:0]  r_idx;
    logic [7:0]  r_pid;
    logic [6:0]  r_addr;
    logic [3:0]  r_endp;
    logic [63:0] r_data;
    logic [4:0]  r_crc5;
    logic [15:0] r_crc16;
    logic        r_bit;
    logic        r_start;
    logic        r_last;

    logic [2:0]  w_nstate;
    logic [5:0]  w_nidx;
    logic [5:0]  w_lim;
    logic        w_nbit;
    logic        w_nlast;
    logic        w_tok;
    logic        w_dat;
    logic [7:0]  w_addr8;
    logic [4:0]  w_crc5;
    logic [15:0] w_crc16;

    assign w_tok   = (r_pid[1:0] == 2'b01);
    assign w_dat   = (r_pid[2:0] == 3'b011);
    assign w_addr8 = {1'b0, r_addr};

    // r_state/r_idx describe the bit currently on bit_out
    always_comb begin
        case (r_state)
            SYNC, PID: w_lim = 6'd7;
            ADDR:      w_lim = 6'd6;
            ENDP:      w_lim = 6'd3;
            CRC5:      w_lim = 6'd4;
            DATA:      w_lim = 6'd63;
            CRC16:     w_lim = 6'd15;
            default:   w_lim = 6'd0;
        endcase
    end

    always_comb begin
        w_nstate = r_state;
        w_nidx   = r_idx + 6'd1;
        if (r_idx == w_lim) begin
            w_nidx = 6'd0;
            case (r_state)
                SYNC:    w_nstate = PID;
                PID:     w_nstate = w_tok ? ADDR : (w_dat ? DATA : IDLE);
                ADDR:    w_nstate = ENDP;
                ENDP:    w_nstate = CRC5;
                DATA:    w_nstate = CRC16;
                default: w_nstate = IDLE;
            endcase
        end
    end

    always_comb begin
        w_nbit  = 1'b0;
        w_nlast = 1'b0;
        case (w_nstate)
            SYNC: w_nbit = (w_nidx == 6'd7);
            PID: begin
                w_nbit  = r_pid[w_nidx[2:0]];
                w_nlast = (w_nidx == 6'd7) && !w_tok && !w_dat;
            end
            ADDR: w_nbit = w_addr8[w_nidx[2:0]];
            ENDP: w_nbit = r_endp[w_nidx[1:0]];
            CRC5: begin
                w_nbit  = ~r_crc5[4];
                w_nlast = (w_nidx == 6'd4);
            end
            DATA: w_nbit = r_data[w_nidx];
            CRC16: begin
                w_nbit  = ~r_crc16[15];
                w_nlast = (w_nidx == 6'd15);
            end
            default: ;
        endcase
    end

    // CRCs absorb each covered bit on the edge that puts it on the wire
    assign w_crc5  = {r_crc5[3:0], 1'b0}
                   ^ ((r_crc5[4] ^ w_nbit) ? 5'b00101 : 5'b00000);
    assign w_crc16 = {r_crc16[14:0], 1'b0}
                   ^ ((r_crc16[15] ^ w_nbit) ? 16'h8005 : 16'h0000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= 6'd0;
            r_pid   <= 8'd0;
            r_addr  <= 7'd0;
            r_endp  <= 4'd0;
            r_data  <= 64'd0;
            r_crc5  <= 5'd0;
            r_crc16 <= 16'd0;
            r_bit   <= 1'b0;
            r_start <= 1'b0;
            r_last  <= 1'b0;
        end else if (r_state == IDLE) begin
            if (pkt_avail) begin
                r_state <= SYNC;
                r_idx   <= 6'd0;
                r_pid   <= pid_in;
                r_addr  <= addr_in;
                r_endp  <= endp_in;
                r_data  <= data_in;
                r_crc5  <= 5'h1F;
                r_crc16 <= 16'hFFFF;
                r_bit   <= 1'b0;
                r_start <= 1'b1;
                r_last  <= 1'b0;
            end
        end else if (!stall) begin
            r_state <= w_nstate;
            r_idx   <= w_nidx;
            r_bit   <= w_nbit;
            r_start <= 1'b0;
            r_last  <= w_nlast;
            if (w_nstate == ADDR || w_nstate == ENDP)
                r_crc5 <= w_crc5;
            if (w_nstate == CRC5)
                r_crc5 <= {r_crc5[3:0], 1'b0};
            if (w_nstate == DATA)
                r_crc16 <= w_crc16;
            if (w_nstate == CRC16)
                r_crc16 <= {r_crc16[14:0], 1'b0};
        end
    end

    assign bit_out = r_bit;
    assign start   = r_start;
    assign last    = r_last;
endmodule

// File: tb/tb_bit_stream_encoder.sv
// Directed bench for bit_stream_encoder: packet contents, markers,
// stall freezing, busy pkt_avail and asynchronous reset.
module tb_bit_stream_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pkt_avail = 1'b0;
    logic [7:0]  pid_in = 8'd0;
    logic [6:0]  addr_in = 7'd0;
    logic [3:0]  endp_in = 4'd0;
    logic [63:0] data_in = 64'd0;
    logic        stall = 1'b0;
    logic        bit_out;
    logic        start;
    logic        last;

    int n_tests = 0;
    int n_fail  = 0;

    bit_stream_encoder dut (
        .clk(clk),
        .rst(rst),
        .pkt_avail(pkt_avail),
        .pid_in(pid_in),
        .addr_in(addr_in),
        .endp_in(endp_in),
        .data_in(data_in),
        .stall(stall),
        .bit_out(bit_out),
        .start(start),
        .last(last)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected streams, packed so the first transmitted bit is the MSB
    function automatic logic [127:0] tok_seq(input logic [7:0] p,
                                             input logic [6:0] a,
                                             input logic [3:0] e);
        logic [127:0] s;
        logic [10:0]  m;
        logic [4:0]   c;
        s = 128'h01;
        for (int i = 0; i < 8; i++) s = {s[126:0], p[i]};
        m = {e, a};
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            s = {s[126:0], m[i]};
            c = (c[4] ^ m[i]) ? ((c << 1) ^ 5'h05) : (c << 1);
        end
        c = ~c;
        for (int i = 4; i >= 0; i--) s = {s[126:0], c[i]};
        return s;
    endfunction

    function automatic logic [127:0] data_seq(input logic [7:0] p,
                                              input logic [63:0] d);
        logic [127:0] s;
        logic [15:0]  c;
        s = 128'h01;
        for (int i = 0; i < 8; i++) s = {s[126:0], p[i]};
        c = 16'hFFFF;
        for (int i = 0; i < 64; i++) begin
            s = {s[126:0], d[i]};
            c = (c[15] ^ d[i]) ? ((c << 1) ^ 16'h8005) : (c << 1);
        end
        c = ~c;
        for (int i = 15; i >= 0; i--) s = {s[126:0], c[i]};
        return s;
    endfunction

    task automatic send(input logic [7:0] p, input logic [6:0] a,
                        input logic [3:0] e, input logic [63:0] d);
        @(negedge clk);
        pid_in    = p;
        addr_in   = a;
        endp_in   = e;
        data_in   = d;
        pkt_avail = 1'b1;
        @(negedge clk);
        pkt_avail = 1'b0;
        pid_in    = ~p;
        addr_in   = ~a;
        endp_in   = ~e;
        data_in   = ~d;
    endtask

    task automatic do_pkt(input string tag, input logic [7:0] p,
                          input logic [6:0] a, input logic [3:0] e,
                          input logic [63:0] d, input int stall_at,
                          input int stall_len, input int pa_at,
                          input logic [127:0] exp_seq, input int exp_n,
                          input int exp_last);
        logic [127:0] seq;
        int n, cyc, lc, sc, sp, frz, left;
        logic held, pb, ps, pl;
        seq = '0;
        n = 0; cyc = 0; lc = 0; sc = 0; sp = 0; frz = 0; left = 0;
        held = 1'b0; pb = 1'b0; ps = 1'b0; pl = 1'b0;
        send(p, a, e, d);
        while (lc == 0 && cyc < 200) begin
            cyc++;
            if (held) begin
                if ({bit_out, start, last} !== {pb, ps, pl}) frz++;
            end else begin
                seq = {seq[126:0], bit_out};
                n++;
                if (start) begin
                    sc++;
                    sp = n;
                end
                if (last) lc = cyc;
            end
            pb = bit_out;
            ps = start;
            pl = last;
            if (!held && n == stall_at && stall_len > 0) left = stall_len;
            held = (left > 0);
            stall = held;
            if (left > 0) left--;
            pkt_avail = (pa_at > 0 && n == pa_at);
            if (lc == 0) @(negedge clk);
        end
        stall = 1'b0;
        pkt_avail = 1'b0;
        check_eq({tag, "_seq"}, seq, exp_seq);
        check_eq({tag, "_nbits"}, 128'(n), 128'(exp_n));
        check_eq({tag, "_last_cyc"}, 128'(lc), 128'(exp_last));
        check_eq({tag, "_start_cnt"}, 128'(sc), 128'(1));
        check_eq({tag, "_start_pos"}, 128'(sp), 128'(1));
        check_eq({tag, "_frozen"}, 128'(frz), 128'(0));
        @(negedge clk);
        check_eq({tag, "_idle"}, 128'({bit_out, start, last}), 128'(0));
    endtask

    initial begin
        int hits;
        #1 rst = 1'b1;
        #3 check_eq("reset_outs", 128'({bit_out, start, last}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_pkt("ack", 8'hD2, 7'd0, 4'd0, 64'd0, 0, 0, 0,
               128'h014B, 16, 16);
        do_pkt("out", 8'hE1, 7'd5, 4'd4, 64'd0, 0, 0, 0,
               128'h0187A041, 32, 32);
        check_eq("out_model", tok_seq(8'hE1, 7'd5, 4'd4), 128'h0187A041);
        do_pkt("out_stall", 8'hE1, 7'd5, 4'd4, 64'd0, 24, 5, 0,
               128'h0187A041, 32, 37);
        do_pkt("data0", 8'hC3, 7'd0, 4'd0, 64'hCAFEBABEDEADBEEF, 0, 0, 0,
               data_seq(8'hC3, 64'hCAFEBABEDEADBEEF), 96, 96);
        check_eq("data0_head", data_seq(8'hC3, 64'hCAFEBABEDEADBEEF) >> 80,
                 128'h01C3);
        do_pkt("in", 8'h69, 7'h3A, 4'hB, 64'd0, 0, 0, 0,
               tok_seq(8'h69, 7'h3A, 4'hB), 32, 32);
        do_pkt("data1_stall", 8'h4B, 7'd0, 4'd0, 64'h0123456789ABCDEF,
               80, 3, 0, data_seq(8'h4B, 64'h0123456789ABCDEF), 96, 99);
        do_pkt("other_pid", 8'h0F, 7'h7F, 4'hF, 64'hFFFF, 0, 0, 0,
               128'h01F0, 16, 16);

        do_pkt("busy_pa", 8'hE1, 7'd5, 4'd4, 64'd0, 0, 0, 10,
               128'h0187A041, 32, 32);
        hits = 0;
        for (int i = 0; i < 120; i++) begin
            if (start === 1'b1 || bit_out === 1'b1) hits++;
            @(negedge clk);
        end
        check_eq("busy_pa_no_queue", 128'(hits), 128'(0));

        send(8'hC3, 7'd0, 4'd0, 64'hCAFEBABEDEADBEEF);
        repeat (9) @(negedge clk);
        check_eq("rst_pre_bit10", 128'(bit_out), 128'(1));
        #2 rst = 1'b1;
        #1 check_eq("rst_async", 128'({bit_out, start, last}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            if ({bit_out, start, last} !== 3'b000) hits++;
            @(negedge clk);
        end
        check_eq("rst_stays_idle", 128'(hits), 128'(0));
        do_pkt("ack_after_rst", 8'hD2, 7'd0, 4'd0, 64'd0, 0, 0, 0,
               128'h014B, 16, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
